l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Responder end of the L1-to-L2 request interface.
- Accepts cacheline read/write requests from two requestors on separate ports: the instruction side (the I-side prefetcher) and the data side (the D-cache).
- Serialises those requests onto the single L2 cache port and routes each L2 response back to the requestor that was granted.
- Sits between the L1 side (prefetcher, D-cache) and the L2 cache.

Parameters:
- ADDR_WIDTH, 16, request address width (lc3b_word).
- LINE_WIDTH, 128, cacheline width (lc3b_cacheline).
- RR_MODE, 1, arbitration policy on a tie: 1 = round-robin, 0 = fixed priority with D-side winning.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_read  input  1  I-side read request, level, held until i_resp.
- i_write  input  1  I-side write request, level, held until i_resp.
- i_address  input  ADDR_WIDTH  I-side line address.
- i_wdata  input  LINE_WIDTH  I-side write data.
- i_resp  output  1  I-side completion pulse.
- i_rdata  output  LINE_WIDTH  I-side read data.
- d_read  input  1  D-side read request, level, held until d_resp.
- d_write  input  1  D-side write request, level, held until d_resp.
- d_address  input  ADDR_WIDTH  D-side line address.
- d_wdata  input  LINE_WIDTH  D-side write data.
- d_resp  output  1  D-side completion pulse.
- d_rdata  output  LINE_WIDTH  D-side read data.
- l2_read  output  1  L2 read request.
- l2_write  output  1  L2 write request.
- l2_address  output  ADDR_WIDTH  L2 address.
- l2_wdata  output  LINE_WIDTH  L2 write data.
- l2_resp  input  1  L2 completion pulse.
- l2_rdata  input  LINE_WIDTH  L2 read data, valid while l2_resp is high.

Behaviour:
- Single clock domain (clk). rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; last_grant = D.
  - Latched op, address and wdata registers = 0.
  - l2_read = l2_write = 0; i_resp = d_resp = 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - req_i = i_read | i_write; req_d = d_read | d_write.
  - Neither requesting: stay in IDLE.
  - Exactly one requesting: go to that requestor's grant state.
  - Both requesting, RR_MODE=1: grant the side that is not last_grant.
  - Both requesting, RR_MODE=0: grant D.
  - On every grant: latch the winner's read bit, write bit, address and wdata into registers, and set last_grant to the winner.
- GRANT_x:
  - l2_read, l2_write, l2_address and l2_wdata are driven only from the latched registers, so they stay stable even if the requestor's inputs change.
  - On l2_resp: x_resp = l2_resp combinationally in the same cycle, qualified by (x_read | x_write) still being high; then go to IDLE.
  - Without l2_resp: hold the grant state.
- Read data: i_rdata and d_rdata are both wired continuously to l2_rdata. Only the resp pulses are steered.
- Latency:
  - A request first visible in IDLE at cycle N drives l2_read/l2_write from cycle N+1.
  - l2_resp at cycle M gives x_resp at cycle M; the FSM is in IDLE at M+1.
  - A pending request is re-arbitrated at M+1 and reaches the L2 port at M+2.
  - Minimum back-to-back spacing on the L2 port is 2 idle-to-grant cycles per transaction.
- l2_read/l2_write fall combinationally with the state change to IDLE, i.e. they are low in cycle M+1.
- Boundary conditions:
  - l2_resp in IDLE: ignored; no resp is generated.
  - Granted requestor drops its request before l2_resp (abort): the grant is held until l2_resp, which is swallowed with no resp to either side. The other requestor never receives a stray resp.
  - Requestor asserts read and write together: both bits are latched and forwarded verbatim. This is illegal upstream and is flagged by an assertion in the bench.
  - A new request from the non-granted side during a grant waits. It is never lost, because the request is level-held.
  - rst_n asserted mid-transaction: the FSM returns to IDLE immediately (asynchronously) and l2_read/l2_write drop to 0. Any later l2_resp for the aborted transaction lands in IDLE and is ignored.
  - Round-robin fairness: with both sides continuously requesting, grants alternate I, D, I, D, …, starting with I after reset.

Test Plan:
- I-only read to 0x1230: i_read held; l2_read=1 and l2_address=0x1230 from cycle +1; L2 returns l2_rdata=0xDEAD…BEEF with l2_resp 3 cycles later -> i_resp pulses 1 cycle; i_rdata matches; d_resp stays 0.
- D-only write to 0x4000 with d_wdata=0xA5 repeated: l2_write=1, l2_wdata equals the pattern; d_resp on l2_resp; l2_read stays 0 throughout.
- Simultaneous I read 0x0010 and D read 0x2000, RR_MODE=1, both held: L2 sees 0x0010 then 0x2000, with ≥1 idle cycle between them; each resp reaches only its own requestor. A repeat pair gives the order I then D again, alternating thereafter.
- Same tie with RR_MODE=0: D at 0x2000 is served first, then I at 0x0010.
- Abort: I drops i_read 1 cycle after grant; D requests during the grant -> l2_address stays at the latched I address until l2_resp; no i_resp or d_resp; D is granted next.
- rst_n pulsed low mid-GRANT_D -> l2_read=0 immediately; a later l2_resp produces no resp; a fresh D request after reset completes normally.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: serialises cacheline requests from the I-side prefetcher and
// the D-cache onto a single L2 port and steers the L2 completion pulse back
// to whichever side was granted.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_read/i_write/i_address/i_wdata   I-side level request, held until i_resp
//   i_resp, i_rdata            I-side completion pulse and read data
//   d_read/d_write/d_address/d_wdata   D-side level request, held until d_resp
//   d_resp, d_rdata            D-side completion pulse and read data
//   l2_read/l2_write/l2_address/l2_wdata   request toward the L2 cache
//   l2_resp, l2_rdata          L2 completion pulse and read data
module l2_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128,
   parameter int RR_MODE    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_read,
   input  logic                  i_write,
   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic [LINE_WIDTH-1:0] i_wdata,
   output logic                  i_resp,
   output logic [LINE_WIDTH-1:0] i_rdata,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_resp,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic                  l2_resp,
   input  logic [LINE_WIDTH-1:0] l2_rdata
);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

   state_e                state_q, state_d;
   logic                  last_d_q, last_d_d;   // 1: D was granted most recently
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

   logic req_i, req_d, pick_d;

   assign req_i = i_read | i_write;
   assign req_d = d_read | d_write;

   // D wins when it is alone, or on a tie when fixed priority is selected
   // or when I had the previous grant under round-robin.
   assign pick_d = req_d & (~req_i | (RR_MODE == 0) | ~last_d_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i | req_d) begin
               state_d  = pick_d ? GRANT_D : GRANT_I;
               last_d_d = pick_d;
               rd_d     = pick_d ? d_read    : i_read;
               wr_d     = pick_d ? d_write   : i_write;
               addr_d   = pick_d ? d_address : i_address;
               wdata_d  = pick_d ? d_wdata   : i_wdata;
            end
         end
         // A requestor that dropped its request (abort) still holds the
         // grant until L2 answers; that answer is swallowed.
         GRANT_I: begin
            if (l2_resp) begin
               i_resp  = req_i;
               state_d = IDLE;
            end
         end
         GRANT_D: begin
            if (l2_resp) begin
               d_resp  = req_d;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // L2 request is taken only from the latched copy so it stays stable
   // while the requestor's inputs move.
   assign l2_read    = rd_q & (state_q != IDLE);
   assign l2_write   = wr_q & (state_q != IDLE);
   assign l2_address = addr_q;
   assign l2_wdata   = wdata_q;

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; each is compared every cycle against a transaction-level
// model of who owns the L2 port, plus directed checks of the test plan.
module tb_l2_arbiter;

   logic         clk, rst_n;
   logic         i_read, i_write, d_read, d_write, l2_resp;
   logic [15:0]  i_address, d_address;
   logic [127:0] i_wdata, d_wdata, l2_rdata;

   logic         i_resp_w [2];
   logic         d_resp_w [2];
   logic [127:0] i_rdata_w [2];
   logic [127:0] d_rdata_w [2];
   logic         l2_read_w [2];
   logic         l2_write_w [2];
   logic [15:0]  l2_address_w [2];
   logic [127:0] l2_wdata_w [2];

   int checks = 0;
   int errors = 0;

   l2_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_resp(i_resp_w[0]), .i_rdata(i_rdata_w[0]),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp_w[0]), .d_rdata(d_rdata_w[0]),
      .l2_read(l2_read_w[0]), .l2_write(l2_write_w[0]),
      .l2_address(l2_address_w[0]), .l2_wdata(l2_wdata_w[0]),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata));

   l2_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .RR_MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_resp(i_resp_w[1]), .i_rdata(i_rdata_w[1]),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp_w[1]), .d_rdata(d_rdata_w[1]),
      .l2_read(l2_read_w[1]), .l2_write(l2_write_w[1]),
      .l2_address(l2_address_w[1]), .l2_wdata(l2_wdata_w[1]),
      .l2_resp(l2_resp), .l2_rdata(l2_rdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Reference: index 0 = round-robin instance, 1 = fixed-priority instance.
   // owner: 0 nobody holds the L2 port, 1 I-side holds it, 2 D-side holds it.
   int           m_owner [2];
   bit           m_last_d [2];
   bit           m_rd [2];
   bit           m_wr [2];
   logic [15:0]  m_addr [2];
   logic [127:0] m_wd [2];
   bit           m_ir [2];
   bit           m_dr [2];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k]  = 0;
         m_last_d[k] = 1'b1;
         m_rd[k]     = 1'b0;
         m_wr[k]     = 1'b0;
         m_addr[k]   = '0;
         m_wd[k]     = '0;
         m_ir[k]     = 1'b0;
         m_dr[k]     = 1'b0;
      end
   endtask

   task automatic model_check();
      if (!rst_n) model_reset();
      if (rst_n) begin
         assert (!(i_read && i_write) && !(d_read && d_write)) else begin
            errors++;
            $error("FAIL rw_excl observed i=%b%b d=%b%b expected not both", i_read, i_write, d_read, d_write);
         end
      end
      for (int k = 0; k < 2; k++) begin
         bit busy;
         busy    = (m_owner[k] != 0);
         m_ir[k] = (m_owner[k] == 1) && l2_resp && (i_read || i_write);
         m_dr[k] = (m_owner[k] == 2) && l2_resp && (d_read || d_write);
         chk($sformatf("l2_read[%0d]", k),    l2_read_w[k],    busy && m_rd[k]);
         chk($sformatf("l2_write[%0d]", k),   l2_write_w[k],   busy && m_wr[k]);
         chk($sformatf("l2_address[%0d]", k), l2_address_w[k], m_addr[k]);
         chk($sformatf("l2_wdata[%0d]", k),   l2_wdata_w[k],   m_wd[k]);
         chk($sformatf("i_resp[%0d]", k),     i_resp_w[k],     m_ir[k]);
         chk($sformatf("d_resp[%0d]", k),     d_resp_w[k],     m_dr[k]);
         chk($sformatf("i_rdata[%0d]", k),    i_rdata_w[k],    l2_rdata);
         chk($sformatf("d_rdata[%0d]", k),    d_rdata_w[k],    l2_rdata);
      end
   endtask

   task automatic model_next();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         bit ri, rd, win_d;
         ri = i_read || i_write;
         rd = d_read || d_write;
         if (m_owner[k] == 0) begin
            if (ri || rd) begin
               if (ri && rd) win_d = (k == 1) ? 1'b1 : !m_last_d[k];
               else          win_d = rd;
               m_owner[k]  = win_d ? 2 : 1;
               m_last_d[k] = win_d;
               m_rd[k]     = win_d ? d_read : i_read;
               m_wr[k]     = win_d ? d_write : i_write;
               m_addr[k]   = win_d ? d_address : i_address;
               m_wd[k]     = win_d ? d_wdata : i_wdata;
            end
         end else if (l2_resp) begin
            m_owner[k] = 0;
         end
      end
   endtask

   // Inputs are set at the falling edge; outputs are checked 1 time unit later.
   task automatic cyc_pre();
      #1;
      model_check();
   endtask

   task automatic cyc_post();
      model_next();
      @(negedge clk);
   endtask

   task automatic cyc();
      cyc_pre();
      cyc_post();
   endtask

   initial begin
      bit ia, da, ir_prev, dr_prev;
      logic [127:0] pat;
      ia = 0; da = 0; ir_prev = 0; dr_prev = 0;
      rst_n = 1'b0;
      i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
      d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
      l2_resp = 0; l2_rdata = '0;
      model_reset();
      @(negedge clk);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // I-only read to 0x1230, L2 answers 3 cycles after the request shows up
      i_read = 1; i_address = 16'h1230;
      cyc();
      cyc_pre();
      chk("t1_l2_read", l2_read_w[0], 1'b1);
      chk("t1_l2_addr", l2_address_w[0], 16'h1230);
      cyc_post();
      cyc(); cyc();
      l2_resp = 1; l2_rdata = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
      cyc_pre();
      chk("t1_i_resp", i_resp_w[0], 1'b1);
      chk("t1_i_rdata", i_rdata_w[0], 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);
      chk("t1_d_resp", d_resp_w[0], 1'b0);
      cyc_post();
      l2_resp = 0; i_read = 0;
      cyc_pre();
      chk("t1_i_resp_pulse", i_resp_w[0], 1'b0);
      chk("t1_l2_read_drop", l2_read_w[0], 1'b0);
      cyc_post();

      // D-only write to 0x4000
      pat = {16{8'hA5}};
      d_write = 1; d_address = 16'h4000; d_wdata = pat;
      cyc();
      cyc_pre();
      chk("t2_l2_write", l2_write_w[0], 1'b1);
      chk("t2_l2_read", l2_read_w[0], 1'b0);
      chk("t2_l2_wdata", l2_wdata_w[0], pat);
      cyc_post();
      l2_resp = 1;
      cyc_pre();
      chk("t2_d_resp", d_resp_w[0], 1'b1);
      chk("t2_i_resp", i_resp_w[0], 1'b0);
      cyc_post();
      l2_resp = 0; d_write = 0;
      cyc();

      // Tie with both held: RR alternates I,D,I,D; fixed priority keeps D
      i_read = 1; i_address = 16'h0010;
      d_read = 1; d_address = 16'h2000;
      for (int t = 0; t < 4; t++) begin
         cyc_pre();
         chk("t3_idle_gap", l2_read_w[0], 1'b0);
         cyc_post();
         cyc_pre();
         chk("t3_rr_addr", l2_address_w[0], (t % 2 == 0) ? 16'h0010 : 16'h2000);
         chk("t3_fp_addr", l2_address_w[1], 16'h2000);
         cyc_post();
         l2_resp = 1; l2_rdata = {4{32'h1000_0000 + 32'(t)}};
         cyc_pre();
         chk("t3_rr_i_resp", i_resp_w[0], (t % 2 == 0));
         chk("t3_rr_d_resp", d_resp_w[0], (t % 2 == 1));
         chk("t3_fp_d_resp", d_resp_w[1], 1'b1);
         cyc_post();
         l2_resp = 0;
      end
      i_read = 0; d_read = 0;
      cyc();

      // Fixed priority tie: D first, then I once D is satisfied
      i_read = 1; i_address = 16'h0010;
      d_read = 1; d_address = 16'h2000;
      cyc();
      cyc_pre();
      chk("t4_fp_first", l2_address_w[1], 16'h2000);
      cyc_post();
      l2_resp = 1;
      cyc();
      l2_resp = 0; d_read = 0;
      cyc();
      cyc_pre();
      chk("t4_fp_second", l2_address_w[1], 16'h0010);
      chk("t4_fp_l2_read", l2_read_w[1], 1'b1);
      cyc_post();
      l2_resp = 1;
      cyc_pre();
      chk("t4_fp_i_resp", i_resp_w[1], 1'b1);
      cyc_post();
      l2_resp = 0; i_read = 0;
      cyc();

      // Abort: I drops after grant, D waits, L2 answer is swallowed
      i_read = 1; i_address = 16'h0ABC;
      cyc();
      cyc();
      i_read = 0; i_address = 16'hFFFF;
      d_read = 1; d_address = 16'h2000;
      cyc_pre();
      chk("t5_addr_held", l2_address_w[0], 16'h0ABC);
      chk("t5_l2_read_held", l2_read_w[0], 1'b1);
      cyc_post();
      cyc();
      l2_resp = 1;
      cyc_pre();
      chk("t5_no_i_resp", i_resp_w[0], 1'b0);
      chk("t5_no_d_resp", d_resp_w[0], 1'b0);
      cyc_post();
      l2_resp = 0;
      cyc();
      cyc_pre();
      chk("t5_d_next", l2_address_w[0], 16'h2000);
      cyc_post();
      l2_resp = 1;
      cyc_pre();
      chk("t5_d_resp", d_resp_w[0], 1'b1);
      cyc_post();
      l2_resp = 0; d_read = 0;
      cyc();

      // Reset in the middle of a D grant
      d_read = 1; d_address = 16'h3000;
      cyc();
      cyc_pre();
      chk("t6_granted", l2_read_w[0], 1'b1);
      cyc_post();
      rst_n = 0;
      cyc_pre();
      chk("t6_rst_l2_read_rr", l2_read_w[0], 1'b0);
      chk("t6_rst_l2_read_fp", l2_read_w[1], 1'b0);
      cyc_post();
      rst_n = 1; d_read = 0;
      cyc();
      l2_resp = 1;
      cyc_pre();
      chk("t6_late_resp", d_resp_w[0], 1'b0);
      cyc_post();
      l2_resp = 0; d_read = 1; d_address = 16'h3004;
      cyc();
      cyc_pre();
      chk("t6_fresh_addr", l2_address_w[0], 16'h3004);
      cyc_post();
      l2_resp = 1;
      cyc_pre();
      chk("t6_fresh_resp", d_resp_w[0], 1'b1);
      cyc_post();
      l2_resp = 0; d_read = 0;
      cyc();

      // Random traffic: requestors hold until their resp (as seen by the
      // round-robin instance) or an occasional abort; L2 answers at random,
      // including while idle.
      for (int c = 0; c < 2000; c++) begin
         if (ia && (ir_prev || $urandom_range(0, 39) == 0)) begin
            i_read = 0; i_write = 0; ia = 0;
         end else if (!ia && $urandom_range(0, 2) == 0) begin
            ia = 1;
            if ($urandom_range(0, 1) == 1) i_read = 1; else i_write = 1;
            i_address = 16'($urandom);
            i_wdata   = {4{$urandom}};
         end else if (ia && $urandom_range(0, 9) == 0) begin
            i_address = 16'($urandom);
         end
         if (da && (dr_prev || $urandom_range(0, 39) == 0)) begin
            d_read = 0; d_write = 0; da = 0;
         end else if (!da && $urandom_range(0, 2) == 0) begin
            da = 1;
            if ($urandom_range(0, 1) == 1) d_read = 1; else d_write = 1;
            d_address = 16'($urandom);
            d_wdata   = {4{$urandom}};
         end else if (da && $urandom_range(0, 9) == 0) begin
            d_wdata = {4{$urandom}};
         end
         l2_resp  = ($urandom_range(0, 2) == 0);
         l2_rdata = {4{$urandom}};
         cyc_pre();
         ir_prev = m_ir[0];
         dr_prev = m_dr[0];
         cyc_post();
      end
      i_read = 0; i_write = 0; d_read = 0; d_write = 0; l2_resp = 0;
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
